// File: rtl/surfturf_fw_pkg.sv
// Shared constants, state type and frame builder for the SURF firmware serializer.
package surfturf_fw_pkg;

  localparam int FW_FRAME_BITS = 11;
  localparam logic FW_CTRL_DATA = 1'b0;
  localparam logic FW_CTRL_MARK = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } fw_ser_state_t;

  // Frame image with the start bit in the MSB so it can be shifted out left.
  function automatic logic [FW_FRAME_BITS-1:0] fw_frame(input logic ctrl, input logic [7:0] payload);
    return {1'b0, ctrl, payload, 1'b1};
  endfunction

endpackage

// File: rtl/surfturf_fw_serializer_bit_strobe.sv
// Bit-period divider: strobes on the last sysclk of every serial bit, cleared at frame start.
module fw_bit_strobe #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic strobe
);

  localparam logic [7:0] DIV_MAX = 8'(BIT_DIV - 1);

  logic [7:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 8'd1;
    end
  end

  assign strobe = run && (div_cnt == DIV_MAX);

endmodule

// File: rtl/surfturf_fw_serializer.sv
// Serializes firmware bytes and mark symbols into 11-bit frames on the masked SURF lines.
//   state | meaning
//   IDLE  | lines high, ready for a byte (data) or a mark request
//   SHIFT | frame shifting out, one bit per BIT_DIV cycles
//   HOLD  | one dead cycle after a mark so upstream can clear its request
module surfturf_fw_serializer
  import surfturf_fw_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic       sysclk_i,
  input  logic       sysclk_rstn_i,
  input  logic [7:0] fw_tdata,
  input  logic       fw_tvalid,
  output logic       fw_tready,
  input  logic [1:0] fw_mark_i,
  output logic       fw_marked_o,
  input  logic [7:0] fw_enable_i,
  output logic [7:0] fw_o,
  output logic       busy_o
);

  fw_ser_state_t state, state_nxt;

  logic [FW_FRAME_BITS-1:0] frame_sr;
  logic [7:0]               mask;
  logic [3:0]               bit_cnt;
  logic                     is_mark;
  logic                     strobe;
  logic                     start_data;
  logic                     start_mark;
  logic                     load;
  logic                     last_bit;

  // Data has priority so a mark is only sent once the upstream FIFO has drained.
  assign start_data = (state == IDLE) && fw_tvalid;
  assign start_mark = (state == IDLE) && !fw_tvalid && (|fw_mark_i);
  assign load       = start_data || start_mark;
  assign last_bit   = strobe && (bit_cnt == 4'(FW_FRAME_BITS - 1));

  fw_bit_strobe #(.BIT_DIV(BIT_DIV)) u_bit_strobe (
    .clk    (sysclk_i),
    .rst_n  (sysclk_rstn_i),
    .clear  (load),
    .run    (state == SHIFT),
    .strobe (strobe)
  );

  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = is_mark ? HOLD : IDLE;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fw_tready   = (state == IDLE);
    busy_o      = (state != IDLE);
    fw_marked_o = (state == SHIFT) && last_bit && is_mark;
  end

  // Shift register refills with ones so the line rests high once the stop bit has left.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      frame_sr <= '1;
      mask     <= '0;
      bit_cnt  <= '0;
      is_mark  <= 1'b0;
    end else if (load) begin
      frame_sr <= start_mark ? fw_frame(FW_CTRL_MARK, {6'b0, fw_mark_i})
                             : fw_frame(FW_CTRL_DATA, fw_tdata);
      mask     <= fw_enable_i;
      bit_cnt  <= '0;
      is_mark  <= start_mark;
    end else if (strobe) begin
      frame_sr <= {frame_sr[FW_FRAME_BITS-2:0], 1'b1};
      bit_cnt  <= last_bit ? '0 : bit_cnt + 4'd1;
    end
  end

  assign fw_o = ~mask | {8{frame_sr[FW_FRAME_BITS-1]}};

endmodule

// File: doc/surfturf_fw_serializer.md
# surfturf_fw_serializer

Sysclk-domain stage directly downstream of the SURF/TURF register core's firmware-update path. It consumes the 8-bit firmware AXI4-Stream and the two mark request bits. It serializes data bytes and mark symbols into framed single-bit streams on up to eight SURF firmware lines, and returns a one-cycle `fw_marked_o` pulse when a mark frame has fully left the wire.

## Interface
Parameters:
- `BIT_DIV`, default 4: sysclk cycles per serial bit; legal range 1–255.

Ports:
- `sysclk_i` input 1: the only clock.
- `sysclk_rstn_i` input 1: reset, asynchronous assert, active-low.
- `fw_tdata` input 8: firmware byte.
- `fw_tvalid` input 1: byte valid.
- `fw_tready` output 1: byte accepted on `fw_tvalid && fw_tready`.
- `fw_mark_i` input 2: mark requests [1:0], level, held by upstream until `fw_marked_o`.
- `fw_marked_o` output 1: one-cycle pulse at the end of a mark frame.
- `fw_enable_i` input 8: per-SURF line enable.
- `fw_o` output 8: serial lines; idle high.
- `busy_o` output 1: high whenever state ≠ IDLE.

## Operation
- Frame format is 11 bits, sent in this order:
  - start (0)
  - ctrl (0 = data, 1 = mark)
  - payload[7:0], MSB first
  - stop (1)
- Data frame payload = accepted `fw_tdata`.
- Mark frame payload = `{6'b0, fw_mark_i}`, sampled at frame start.
- States and transitions:
  - IDLE: line high.
    - `fw_tvalid` → accept byte, go to SHIFT (data).
    - Else `|fw_mark_i` → go to SHIFT (mark).
  - SHIFT: frame in progress.
    - Stop bit done, data frame → IDLE.
    - Stop bit done, mark frame → HOLD, and `fw_marked_o` = 1 that cycle.
  - HOLD: one cycle, no new frame. This covers the cycle in which upstream clears its mark bits, so a stale mark is never re-sent. HOLD → IDLE.
- Priority: data wins over mark. A mark is therefore emitted only once the upstream FIFO shows not-valid, which orders it after all queued data.
- `fw_tready` = (state == IDLE); it is combinational from state only, not from `fw_tvalid`.
- `fw_enable_i` is captured at frame start into an 8-bit mask register.
  - `fw_o[i]` = mask[i] ? serial bit : 1.
  - Changing the enable mid-frame has no effect until the next frame.
- `fw_mark_i` changes during SHIFT are ignored. A mark request with both bits set produces a single frame with payload 0x03.
- `fw_tvalid` rising during a mark frame is held off; the byte is accepted in the next IDLE.

## Timing
- Reset values, with async assertion taking effect immediately (including mid-frame):
  - `fw_o` = 8'hFF
  - `fw_tready` = 1 (IDLE)
  - `fw_marked_o` = 0
  - `busy_o` = 0
  - mask = 0
  - bit counter = 0, divider = 0
- Deassertion is synchronized by the instantiating level; the block needs no internal sync.
- Acceptance occurs at cycle 0.
  - The start bit appears on `fw_o` at cycle 1 (registered output).
  - Each bit is held exactly `BIT_DIV` cycles.
  - The stop bit ends at cycle 11·`BIT_DIV`.
- Data → data back-to-back: one IDLE cycle, so the period is 11·`BIT_DIV` + 1 cycles.
- `fw_marked_o` pulses on the final cycle of the stop bit. HOLD occupies the next cycle, and IDLE is reached after that.
- The divider counts 0..`BIT_DIV`-1 and wraps. The bit counter counts 0..10; the frame ends when both are at maximum.
- `BIT_DIV` = 1 must work, giving one bit per cycle.

## Structure
- Shared package `surfturf_fw_pkg`:
  - `FW_FRAME_BITS` = 11
  - `FW_CTRL_DATA` = 0, `FW_CTRL_MARK` = 1
  - state enum `fw_ser_state_t` {IDLE, SHIFT, HOLD}
- One sub-module is natural: `fw_bit_strobe`, a `BIT_DIV` divider that produces the bit-boundary strobe and is cleared at frame start.
- The frame is held in an 11-bit shift register loaded at frame start; `fw_o` is driven from its MSB through the mask.

## Test plan
- Reset mid-frame: assert reset during the 5th bit → `fw_o` = 8'hFF immediately; after release `fw_tready` = 1 and `busy_o` = 0.
- `BIT_DIV` = 4, enable 8'hFF, single byte 0xA5 → lines show 0,0,1,0,1,0,0,1,0,1,1, each held 4 cycles starting 1 cycle after acceptance; `fw_tready` low for 44 cycles.
- Three bytes 0x01, 0x80, 0xFF presented back-to-back → accepts spaced exactly 45 cycles apart; decoded stream matches.
- Mark: `fw_mark_i` = 2'b10 with `fw_tvalid` low; bench drops the mark one cycle after `fw_marked_o` → one frame with ctrl = 1 and payload 0x02; exactly one `fw_marked_o` pulse; no second mark frame.
- Ordering: `fw_mark_i` = 2'b01 rises while two bytes are pending → both data frames go first, then the mark frame.
- Enable mask: enable 8'h0F at frame start, switched to 8'hF0 mid-frame → lines 3:0 carry the frame and lines 7:4 stay 1 for the whole frame; the next frame uses 8'hF0.
